// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel registered stream mux with fixed-select or round-robin grant.
// Define RR_STREAM_MUX_PARITY_EN to add a registered even-parity output out_parity.
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef RR_STREAM_MUX_PARITY_EN
    ,
    output logic                 out_parity
`endif
);
    localparam int PW = 2**SELW;
    if (SELW != $clog2(NCH)) begin : g_selw_check
        $error("rr_stream_mux: SELW must equal clog2(NCH)");
    end
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_g;
    logic [SELW-1:0]  g;
    logic [PW-1:0]    valid_pad;
    logic             rr_hit;
    logic             hit;
    logic             load_en;
    logic [WIDTH-1:0] g_data;
    assign load_en   = !out_valid || out_ready;
    // Zero-padding makes selects beyond NCH-1 read as invalid, so they never grant.
    assign valid_pad = PW'(in_valid);
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[SELW'((int'(ptr) + i) % NCH)]) begin
                rr_hit = 1'b1;
                rr_g   = SELW'((int'(ptr) + i) % NCH);
            end
        end
    end
    assign hit      = mode ? rr_hit : valid_pad[sel];
    assign g        = mode ? rr_g : sel;
    assign g_data   = in_data[int'(g)*WIDTH +: WIDTH];
    assign in_ready = hit ? (NCH'(load_en) << g) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= hit;
            if (hit) begin
                out_data <= g_data;
                out_ch   <= g;
                if (mode)
                    ptr <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
            end
        end
    end
`ifdef RR_STREAM_MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (load_en && hit)
            out_parity <= ^g_data;
    end
`endif
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed checks of rr_stream_mux (NCH=4 main instance, NCH=3 select-range instance).
module tb_rr_stream_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
`ifdef RR_STREAM_MUX_PARITY_EN
    logic        out_parity;
    logic        out_parity3;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pat [4] = '{8'h95, 8'h43, 8'hBF, 8'h45};
    logic       par [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef RR_STREAM_MUX_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode), .sel(sel), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready)
`ifdef RR_STREAM_MUX_PARITY_EN
        , .out_parity(out_parity3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_data   = {pat[3], pat[2], pat[1], pat[0]};
        in_valid  = 4'b0000;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        in_data3  = {8'hBF, 8'h43, 8'h95};
        in_valid3 = 3'b000;
        // reset held across clock edges
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
`ifdef RR_STREAM_MUX_PARITY_EN
        chk("rst_parity", out_parity, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // fixed select
        in_valid = 4'hF;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("fix_ready", in_ready, 4'b0001 << s);
            tick();
            chk("fix_data", out_data, pat[s]);
            chk("fix_ch", out_ch, s);
            chk("fix_valid", out_valid, 1);
`ifdef RR_STREAM_MUX_PARITY_EN
            chk("fix_parity", out_parity, par[s]);
`endif
        end
        // round-robin, all valid
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_all_ch", out_ch, i % 4);
            chk("rr_all_data", out_data, pat[i % 4]);
        end
        // round-robin, ch1 and ch3 valid
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_alt_ch", out_ch, (i % 2 == 0) ? 1 : 3);
        end
        // backpressure holding ch3 beat
        out_ready = 1'b0;
        #1;
        chk("bp_ready", in_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ch", out_ch, 3);
            chk("bp_data", out_data, pat[3]);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready_hold", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_ready", in_ready, 4'b0010);
        tick();
        chk("drain_ch", out_ch, 1);
        chk("drain_data", out_data, pat[1]);
        chk("drain_valid", out_valid, 1);
        // fixed select of an invalid channel
        mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("idle_ready", in_ready, 4'b0000);
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_ch_hold", out_ch, 1);
        chk("idle_data_hold", out_data, pat[1]);
        // NCH=3: sel=3 is out of range
        sel = 2'd3;
        in_valid3 = 3'b111;
        #1;
        chk("n3_sel3_ready", in_ready3, 3'b000);
        tick();
        chk("n3_sel3_valid", out_valid3, 0);
        tick();
        chk("n3_sel3_valid2", out_valid3, 0);
        sel = 2'd2;
        #1;
        chk("n3_sel2_ready", in_ready3, 3'b100);
        tick();
        chk("n3_sel2_ch", out_ch3, 2);
        chk("n3_sel2_data", out_data3, 8'hBF);
        // reset mid-operation with ptr=2
        mode = 1'b1;
        in_valid = 4'b0010;
        tick();
        chk("pre_rst_ch", out_ch, 1);
        in_valid = 4'hF;
        #1;
        chk("pre_rst_ptr", in_ready, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ch", out_ch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ch0", out_ch, 0);
        chk("post_rst_valid", out_valid, 1);
        tick();
        chk("post_rst_ch1", out_ch, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
